// File: rtl/wb_byte_copy_master.sv
// Wishbone classic initiator that copies a byte range or fills it with a constant.
// One access at a time; every access is followed by an idle GAP cycle except the final write.
module wb_byte_copy_master #(
   parameter int unsigned AW      = 11,
   parameter int unsigned LW      = 12,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          mode_i,
   input  logic [AW-1:0] src_i,
   input  logic [AW-1:0] dst_i,
   input  logic [LW-1:0] len_i,
   input  logic [7:0]    fill_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [AW-1:0] adr_o,
   output logic [7:0]    dat_o,
   input  logic [7:0]    dat_i,
   output logic          we_o,
   output logic          cyc_o,
   output logic          stb_o,
   output logic          sel_o,
   input  logic          ack_i,
   input  logic          err_i
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_GAP,
      S_FIN
   } state_e;

   state_e        state_q, nxt_q;
   logic          mode_q;
   logic [AW-1:0] src_q, dst_q;
   logic [LW-1:0] cnt_q;
   logic [7:0]    fill_q, rdata_q;
   logic [TW-1:0] wait_q;
   logic          busy_q, done_q, err_q, we_q, cyc_q, stb_q;
   logic [AW-1:0] adr_q;
   logic [7:0]    dat_q;

   logic [TW:0]   wait_inc_d;
   logic [LW-1:0] cnt_d;
   logic          timeout_c, abort_c;

   // Strobe wait counter: abort fires on the edge where the count reaches TIMEOUT.
   assign wait_inc_d = {1'b0, wait_q} + (TW+1)'(1);
   assign timeout_c  = (TIMEOUT != 0) && (wait_inc_d == (TW+1)'(TIMEOUT));
   assign abort_c    = err_i || (timeout_c && !ack_i);
   assign cnt_d      = cnt_q - LW'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         nxt_q   <= S_IDLE;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= '0;
         rdata_q <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  mode_q <= mode_i;
                  src_q  <= src_i;
                  dst_q  <= dst_i;
                  cnt_q  <= len_i;
                  fill_q <= fill_i;
                  err_q  <= 1'b0;
                  if (len_i == '0) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     busy_q <= 1'b1;
                     cyc_q  <= 1'b1;
                     stb_q  <= 1'b1;
                     wait_q <= '0;
                     if (mode_i) begin
                        state_q <= S_WR;
                        we_q    <= 1'b1;
                        adr_q   <= dst_i;
                        dat_q   <= fill_i;
                     end else begin
                        state_q <= S_RD;
                        we_q    <= 1'b0;
                        adr_q   <= src_i;
                     end
                  end
               end
            end
            S_RD, S_WR: begin
               if (abort_c) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_FIN;
               end else if (ack_i) begin
                  cyc_q <= 1'b0;
                  stb_q <= 1'b0;
                  we_q  <= 1'b0;
                  if (state_q == S_RD) begin
                     rdata_q <= dat_i;
                     nxt_q   <= S_WR;
                     state_q <= S_GAP;
                  end else begin
                     src_q <= src_q + AW'(1);
                     dst_q <= dst_q + AW'(1);
                     cnt_q <= cnt_d;
                     if (cnt_d == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                     end else begin
                        nxt_q   <= mode_q ? S_WR : S_RD;
                        state_q <= S_GAP;
                     end
                  end
               end else begin
                  wait_q <= wait_inc_d[TW-1:0];
               end
            end
            S_GAP: begin
               state_q <= nxt_q;
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
               wait_q  <= '0;
               if (nxt_q == S_WR) begin
                  we_q  <= 1'b1;
                  adr_q <= dst_q;
                  dat_q <= mode_q ? fill_q : rdata_q;
               end else begin
                  we_q  <= 1'b0;
                  adr_q <= src_q;
               end
            end
            S_FIN: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign adr_o  = adr_q;
   assign dat_o  = dat_q;
   assign we_o   = we_q;
   assign cyc_o  = cyc_q;
   assign stb_o  = stb_q;
   assign sel_o  = stb_q;

endmodule
